// File: rtl/clock_pkg.sv
// Shared types, terminal values and the BCD increment helper for the clock controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;
    localparam logic [7:0] SEC_MAX_BCD  = 8'h59;

    // Two-digit BCD increment; the terminal value wraps to 00.
    function automatic logic [7:0] bcd_inc(input byte unsigned value, input byte unsigned max);
        logic [7:0] v;
        v = value;
        if (v == max) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Tick, key and display signals between the clock controller and its surroundings.
interface clock_ctrl_if;
    import clock_pkg::*;

    logic       tick;
    logic       btn_mode_n;
    logic       btn_inc_n;
    logic       div_rst;
    mode_t      mode;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       blink;

    modport master (
        output tick, btn_mode_n, btn_inc_n,
        input  div_rst, mode, hour_bcd, min_bcd, sec_bcd, blink
    );

    modport slave (
        input  tick, btn_mode_n, btn_inc_n,
        output div_rst, mode, hour_bcd, min_bcd, sec_bcd, blink
    );

endinterface

// File: rtl/btn_debounce.sv
// Key conditioner: 2-FF synchronizer, stable-level debounce counter, press edge detect.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Synchronize, count consecutive samples differing from the accepted level, flip on the
    // last one and flag a press only when the new level is low.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// 24 h BCD timekeeper with a two-key set-mode FSM and divider re-phasing on exit from set mode.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input logic        clk_in,
    input logic        rst,
    clock_ctrl_if.slave bus
);

    logic       mode_press;
    logic       inc_press;
    mode_t      state;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       blink;
    logic       div_rst;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_n  (bus.btn_mode_n),
        .press  (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_n  (bus.btn_inc_n),
        .press  (inc_press)
    );

    // Mode FSM and time registers; a mode press wins over any tick or inc in the same cycle.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state   <= RUN;
            hour    <= 8'h00;
            min     <= 8'h00;
            sec     <= 8'h00;
            blink   <= 1'b0;
            div_rst <= 1'b0;
        end else begin
            div_rst <= 1'b1;
            if (mode_press) begin
                blink <= 1'b0;
                unique case (state)
                    RUN: begin
                        state <= SET_HOUR;
                        sec   <= 8'h00;
                    end
                    SET_HOUR: state <= SET_MIN;
                    SET_MIN: begin
                        state   <= RUN;
                        div_rst <= 1'b0;  // restart the divider so the next second is full
                    end
                    default: state <= RUN;
                endcase
            end else begin
                unique case (state)
                    RUN: begin
                        blink <= 1'b0;
                        if (bus.tick) begin
                            sec <= bcd_inc(sec, SEC_MAX_BCD);
                            if (sec == SEC_MAX_BCD) begin
                                min <= bcd_inc(min, MIN_MAX_BCD);
                                if (min == MIN_MAX_BCD) begin
                                    hour <= bcd_inc(hour, HOUR_MAX_BCD);
                                end
                            end
                        end
                    end
                    SET_HOUR: begin
                        if (bus.tick) blink <= ~blink;
                        if (inc_press) hour <= bcd_inc(hour, HOUR_MAX_BCD);
                    end
                    SET_MIN: begin
                        if (bus.tick) blink <= ~blink;
                        if (inc_press) min <= bcd_inc(min, MIN_MAX_BCD);
                    end
                    default: begin
                        state <= RUN;
                        blink <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mode     = state;
    assign bus.hour_bcd = hour;
    assign bus.min_bcd  = min;
    assign bus.sec_bcd  = sec;
    assign bus.blink    = blink;
    assign bus.div_rst  = div_rst;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with a short debounce window.
module tb_clock_ctrl;
    import clock_pkg::*;

    localparam int unsigned DEB = 4;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   lows;

    clock_ctrl_if bus ();

    clock_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
        chk({tag, ".hour"}, bus.hour_bcd, h);
        chk({tag, ".min"}, bus.min_bcd, m);
        chk({tag, ".sec"}, bus.sec_bcd, s);
    endtask

    // Hold a key low for 'hold' cycles, release, and count cycles with div_rst low.
    task automatic press(input bit is_mode, input int hold, output int low_cnt);
        low_cnt = 0;
        if (is_mode) bus.btn_mode_n = 1'b0;
        else         bus.btn_inc_n  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (bus.div_rst === 1'b0) low_cnt++;
        end
        bus.btn_mode_n = 1'b1;
        bus.btn_inc_n  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.div_rst === 1'b0) low_cnt++;
        end
    endtask

    task automatic presses(input bit is_mode, input int n);
        int l;
        for (int i = 0; i < n; i++) press(is_mode, 12, l);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
        end
    endtask

    initial begin
        bus.tick       = 1'b0;
        bus.btn_mode_n = 1'b1;
        bus.btn_inc_n  = 1'b1;

        // Reset
        repeat (3) step();
        chk("rst.div_rst", {7'b0, bus.div_rst}, 8'h00);
        chk("rst.mode", {6'b0, bus.mode}, 8'h00);
        chk("rst.blink", {7'b0, bus.blink}, 8'h00);
        chk_time("rst", 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        step();
        chk("rel.div_rst", {7'b0, bus.div_rst}, 8'h01);

        // Running seconds, inc ignored in RUN
        ticks(3);
        chk_time("run3", 8'h00, 8'h00, 8'h03);
        press(1'b0, 12, lows);
        chk_time("run.inc", 8'h00, 8'h00, 8'h03);

        // Enter SET_HOUR clears seconds
        press(1'b1, 12, lows);
        chk("sh.mode", {6'b0, bus.mode}, 8'h01);
        chk("sh.sec", bus.sec_bcd, 8'h00);
        chk("sh.divlow", lows[7:0], 8'h00);

        // Debounce: glitch ignored, long hold gives one event
        press(1'b0, 3, lows);
        chk("deb.short", bus.hour_bcd, 8'h00);
        press(1'b0, 20, lows);
        chk("deb.long", bus.hour_bcd, 8'h01);

        // Hour wrap
        presses(1'b0, 8);
        chk("h09", bus.hour_bcd, 8'h09);
        presses(1'b0, 1);
        chk("h10", bus.hour_bcd, 8'h10);
        presses(1'b0, 13);
        chk("h23", bus.hour_bcd, 8'h23);
        presses(1'b0, 1);
        chk_time("hwrap", 8'h00, 8'h00, 8'h00);

        // Minute wrap without carry
        press(1'b1, 12, lows);
        chk("sm.mode", {6'b0, bus.mode}, 8'h02);
        presses(1'b0, 59);
        chk("m59", bus.min_bcd, 8'h59);
        presses(1'b0, 2);
        chk_time("mwrap", 8'h00, 8'h01, 8'h00);

        // Set to 23:59
        presses(1'b0, 58);
        press(1'b1, 12, lows);
        chk("exit1.divlow", lows[7:0], 8'h01);
        press(1'b1, 12, lows);
        presses(1'b0, 23);
        press(1'b1, 12, lows);
        chk_time("set2359", 8'h23, 8'h59, 8'h00);
        press(1'b1, 12, lows);
        chk("exit2.mode", {6'b0, bus.mode}, 8'h00);
        chk("exit2.divlow", lows[7:0], 8'h01);
        chk("exit2.div_rst", {7'b0, bus.div_rst}, 8'h01);

        // Carry through midnight
        ticks(59);
        chk_time("t235959", 8'h23, 8'h59, 8'h59);
        ticks(1);
        chk_time("midnight", 8'h00, 8'h00, 8'h00);

        // Blink in set mode, time frozen
        press(1'b1, 12, lows);
        press(1'b1, 12, lows);
        chk("blink0", {7'b0, bus.blink}, 8'h00);
        ticks(1);
        chk("blink1", {7'b0, bus.blink}, 8'h01);
        ticks(1);
        chk("blink2", {7'b0, bus.blink}, 8'h00);
        ticks(1);
        chk("blink3", {7'b0, bus.blink}, 8'h01);
        chk_time("frozen", 8'h00, 8'h00, 8'h00);
        press(1'b1, 12, lows);
        chk("run.blink", {7'b0, bus.blink}, 8'h00);
        chk("run.mode", {6'b0, bus.mode}, 8'h00);

        // Tick and mode press in the same cycle: the tick is discarded
        ticks(59);
        chk_time("t59", 8'h00, 8'h00, 8'h59);
        bus.btn_mode_n = 1'b0;
        repeat (6) step();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("sim.mode", {6'b0, bus.mode}, 8'h01);
        chk_time("sim", 8'h00, 8'h00, 8'h00);
        repeat (6) step();
        bus.btn_mode_n = 1'b1;
        repeat (10) step();

        // Reset mid-operation and mid-debounce
        presses(1'b0, 1);
        chk("pre.hour", bus.hour_bcd, 8'h01);
        bus.btn_inc_n = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        step();
        chk("mid.mode", {6'b0, bus.mode}, 8'h00);
        chk("mid.div_rst", {7'b0, bus.div_rst}, 8'h00);
        chk_time("mid", 8'h00, 8'h00, 8'h00);
        bus.btn_inc_n = 1'b1;
        rst = 1'b1;
        repeat (12) step();
        chk("post.hour", bus.hour_bcd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
